io_uart_tx: RTL and testbench



---
 rtl/grom_io_pkg.sv | 25 ++
 rtl/io_uart_tx_if.sv | 12 +
 rtl/io_sync_fifo.sv | 52 +++++
 rtl/io_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_io_uart_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grom_io_pkg.sv
// Shared definitions for the CPU IO-bus peripherals: UART FSM states,
// status-register bit positions and default port addresses.
package grom_io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [7:0] IO_UART_DATA_ADDR = 8'h01;

  // The status port sits directly above the data port, wrapping in 8 bits.
  function automatic logic [7:0] stat_addr(input logic [7:0] data_addr);
    return data_addr + 8'd1;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU IO-bus slice seen by an IO-mapped peripheral: cycle qualifier,
// write strobe, address, write data and registered read data.
interface io_uart_tx_if;
  logic       i_ioreq;
  logic       i_we;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;

  modport master (output i_ioreq, i_we, i_addr, i_data, input o_data);
  modport slave  (input i_ioreq, i_we, i_addr, i_data, output o_data);
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; push while full
// and pop while empty are ignored. Pointers carry one extra wrap bit.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);

  // Flags are pre-edge: a push while full is lost even if a pop happens too.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wptr_d  = wptr_q + (AW + 1)'(do_push);
  assign rptr_d  = rptr_q + (AW + 1)'(do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// IO-mapped UART transmitter: data-port writes queue bytes, an 8N1 serializer
// drains them onto o_tx. Defining UART_PARITY_EN inserts an even-parity bit.
module io_uart_tx
  import grom_io_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] PORT_ADDR    = IO_UART_DATA_ADDR
) (
  input  logic         clk,
  input  logic         reset,
  io_uart_tx_if.slave  bus,
  output logic         o_tx,
  output logic         o_full,
  output logic         o_busy
);

  localparam int         CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] STAT_ADDR = stat_addr(PORT_ADDR);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rdata_q, rdata_d;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       wr_hit;
  logic       rd_hit;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       baud_last;

  assign wr_hit    = bus.i_ioreq &  bus.i_we & (bus.i_addr == PORT_ADDR);
  assign rd_hit    = bus.i_ioreq & ~bus.i_we & (bus.i_addr == STAT_ADDR);
  assign baud_last = (cnt_q == CNT_LAST);

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (wr_hit),
    .wdata_i (bus.i_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_full   = fifo_full;
  assign o_busy   = (state_q != IDLE) | ~fifo_empty;
  assign bus.o_data = rdata_q;

  // Status snapshot uses pre-edge flags; the read also clears overflow.
  always_comb begin
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (rd_hit) begin
      rdata_d             = 8'h00;
      rdata_d[STAT_FULL]  = fifo_full;
      rdata_d[STAT_EMPTY] = fifo_empty;
      rdata_d[STAT_BUSY]  = o_busy;
      rdata_d[STAT_OVF]   = ovf_q;
      ovf_d               = 1'b0;
    end
    if (wr_hit && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    o_tx     = 1'b1;
`ifdef UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = '0;
          state_d  = START;
`ifdef UART_PARITY_EN
          par_d    = ^fifo_rdata;
`endif
        end
      end
      START: begin
        o_tx  = 1'b0;
        cnt_d = baud_last ? '0 : cnt_q + CW'(1);
        if (baud_last) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        o_tx  = shift_q[0];
        cnt_d = baud_last ? '0 : cnt_q + CW'(1);
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        o_tx  = par_q;
        cnt_d = baud_last ? '0 : cnt_q + CW'(1);
        if (baud_last) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = baud_last ? '0 : cnt_q + CW'(1);
        if (baud_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      ovf_q   <= 1'b0;
      rdata_q <= 8'h00;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed and random IO cycles checked every clock
// against a frame-timeline model of the FIFO and serial line.
module tb_io_uart_tx;

  localparam int         CPB   = 4;
  localparam int         DEPTH = 4;
  localparam logic [7:0] PA    = 8'h01;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic reset;
  logic o_tx, o_full, o_busy;

  io_uart_tx_if bus();

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .PORT_ADDR    (PA)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .o_tx   (o_tx),
    .o_full (o_full),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: each accepted byte gets the edge at which the serializer pops it.
  int         f_pop[$];
  logic [7:0] f_byte[$];
  int         free_at = 0;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int occ_from(input int t);
    int n;
    n = 0;
    foreach (f_pop[i]) if (f_pop[i] >= t) n++;
    return n;
  endfunction

  function automatic logic active(input int e);
    logic r;
    r = 1'b0;
    foreach (f_pop[i]) if (e >= f_pop[i] && e < f_pop[i] + FRAME) r = 1'b1;
    return r;
  endfunction

  function automatic logic exp_tx(input int e);
    logic       r;
    int         k;
    logic [7:0] b;
    r = 1'b1;
    for (int i = 0; i < f_pop.size(); i++) begin
      if (e >= f_pop[i] && e < f_pop[i] + FRAME) begin
        k = (e - f_pop[i]) / CPB;
        b = f_byte[i];
        if (k == 0) r = 1'b0;
        else if (k <= 8) r = b[k-1];
`ifdef UART_PARITY_EN
        else if (k == 9) r = ^b;
`endif
        else r = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    f_pop.delete();
    f_byte.delete();
    free_at = 0;
    m_ovf   = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic model_edge();
    int   e, occ, p;
    logic full_pre, busy_pre;
    e        = cyc;
    occ      = occ_from(e);
    full_pre = (occ == DEPTH);
    busy_pre = (occ > 0) || active(e - 1);
    if (bus.i_ioreq && !bus.i_we && bus.i_addr == PA + 8'd1) begin
      m_rdata = {4'b0000, m_ovf, busy_pre, occ == 0, full_pre};
      m_ovf   = 1'b0;
    end
    if (bus.i_ioreq && bus.i_we && bus.i_addr == PA) begin
      if (full_pre) begin
        m_ovf = 1'b1;
      end else begin
        p = (e + 1 > free_at) ? e + 1 : free_at;
        f_pop.push_back(p);
        f_byte.push_back(bus.i_data);
        free_at = p + FRAME + 1;
      end
    end
  endtask

  task automatic check_outputs();
    int occ;
    occ = occ_from(cyc + 1);
    check_eq("tx",    o_tx,       exp_tx(cyc));
    check_eq("full",  o_full,     occ == DEPTH);
    check_eq("busy",  o_busy,     (occ > 0) || active(cyc));
    check_eq("rdata", bus.o_data, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.i_ioreq = rq;
    bus.i_we    = we;
    bus.i_addr  = a;
    bus.i_data  = d;
  endtask

  task automatic wr(input logic [7:0] b);
    drive(1'b1, 1'b1, PA, b);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rd();
    drive(1'b1, 1'b0, PA + 8'd1, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain();
    while (cyc < free_at) step();
    step();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int tries;
    int tgt;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1 reset = 1'b0;
    check_eq("rst_tx",    o_tx,       1'b1);
    check_eq("rst_full",  o_full,     1'b0);
    check_eq("rst_busy",  o_busy,     1'b0);
    check_eq("rst_rdata", bus.o_data, 8'h00);
    repeat (3) step();
    rd();
    check_eq("rst_stat", bus.o_data, 8'h02);

    // Single byte, then back-to-back 00/FF with one idle clock between frames.
    wr(8'hA5);
    drain();
    wr(8'h00);
    wr(8'hFF);
    drain();

    // Overflow: serializer busy, five more writes, the fifth is dropped.
    wr(8'h11);
    wr(8'h21);
    wr(8'h32);
    wr(8'h43);
    wr(8'h54);
    check_eq("ovf_full_after4", o_full, 1'b1);
    wr(8'h65);
    rd();
    check_eq("ovf_stat1_bit3", bus.o_data[3], 1'b1);
    rd();
    check_eq("ovf_stat2_bit3", bus.o_data[3], 1'b0);
    drain();

    // Ten polled writes wrap the pointers without any overflow.
    for (int b = 0; b < 10; b++) begin
      tries = 0;
      rd();
      while (bus.o_data[0] && tries < 500) begin
        rd();
        tries++;
      end
      check_eq("poll_bound", tries < 500, 1'b1);
      wr(8'(b * 37 + 5));
    end
    rd();
    check_eq("wrap_no_ovf", bus.o_data[3], 1'b0);
    drain();

    // Parity-sensitive patterns (odd and even population).
    wr(8'h07);
    drain();
    wr(8'h03);
    drain();

    for (int i = 0; i < 1500; i++) begin
      int         r;
      logic [7:0] d;
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      if (r < 4)       drive(1'b1, 1'b1, PA, d);
      else if (r < 16) drive(1'b1, 1'b0, PA + 8'd1, 8'h00);
      else if (r < 26) drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), d);
      else             drive(1'b0, 1'($urandom_range(0, 1)), PA, d);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drain();

    // Reset during data bit 3 of A5 (a 0 bit) with further bytes queued.
    wr(8'hA5);
    wr(8'h3C);
    wr(8'h77);
    tgt = f_pop[0] + 4 * CPB + 1;
    while (cyc < tgt) step();
    check_eq("pre_rst_bit3", o_tx, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("rstmid_tx",   o_tx,   1'b1);
    check_eq("rstmid_busy", o_busy, 1'b0);
    check_eq("rstmid_full", o_full, 1'b0);
    model_clear();
    @(posedge clk);
    cyc++;
    #1 reset = 1'b0;
    check_outputs();
    repeat (50) step();
    rd();
    check_eq("rstmid_stat", bus.o_data, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
